// File: rtl/packet_serializer.sv
// Flit packet transmitter: takes a whole packet and streams it as HEAD/BODY.../TAIL flits,
// stamping packet_id and flit_num so the receiving packet buffer can reassemble it.
package types;
    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_type_e;

    typedef struct packed {
        logic [7:0] packet_id;
        logic [3:0] flit_num;
    } flit_id_t;

    typedef struct packed {
        flit_type_e  flittype;
        flit_id_t    flit_id;
        logic [31:0] payload;
    } flit_t;
endpackage

module packet_serializer #(
    parameter int MAX_FLITS   = 8,
    parameter int PACKET_ID_W = 8,
    parameter int FLIT_NUM_W  = $clog2(MAX_FLITS + 1)
) (
    input  logic                           nocclk,
    input  logic                           rst_n,
    input  types::flit_t [MAX_FLITS-1:0]   pkt_flits,
    input  logic [FLIT_NUM_W-1:0]          pkt_num_flits,
    input  logic                           pkt_valid,
    output logic                           pkt_ready,
    output types::flit_t                   flit_out,
    output logic                           flit_valid,
    input  logic                           flit_ready,
    output logic                           tx_done,
    output logic [PACKET_ID_W-1:0]         tx_done_id,
    output logic                           err_len
);

    localparam int IDX_W = $clog2(MAX_FLITS);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_SEND = 1'b1;

    localparam logic [FLIT_NUM_W-1:0] NUM_ONE = FLIT_NUM_W'(1);
    localparam logic [FLIT_NUM_W-1:0] NUM_MIN = FLIT_NUM_W'(2);
    localparam logic [FLIT_NUM_W-1:0] NUM_MAX = FLIT_NUM_W'(MAX_FLITS);

    logic                          state_q,      state_d;
    types::flit_t [MAX_FLITS-1:0]  flits_q,      flits_d;
    logic [FLIT_NUM_W-1:0]         num_q,        num_d;
    logic [FLIT_NUM_W-1:0]         idx_q,        idx_d;
    logic [PACKET_ID_W-1:0]        id_ctr_q,     id_ctr_d;
    types::flit_t                  flit_out_q,   flit_out_d;
    logic                          flit_valid_q, flit_valid_d;
    logic                          pkt_ready_q,  pkt_ready_d;
    logic                          tx_done_q,    tx_done_d;
    logic [PACKET_ID_W-1:0]        tx_done_id_q, tx_done_id_d;
    logic                          err_len_q,    err_len_d;

    logic [FLIT_NUM_W-1:0]         idx_nxt;
    logic                          len_ok;

    // Overwrite the header fields of a stored flit; the payload passes through untouched.
    function automatic types::flit_t stamp(input types::flit_t          raw,
                                           input logic [FLIT_NUM_W-1:0]  idx,
                                           input logic [FLIT_NUM_W-1:0]  num,
                                           input logic [PACKET_ID_W-1:0] id);
        types::flit_t f;
        f = raw;
        if (idx == '0)
            f.flittype = types::HEAD;
        else if (idx == num - NUM_ONE)
            f.flittype = types::TAIL;
        else
            f.flittype = types::BODY;
        f.flit_id.packet_id = id;
        f.flit_id.flit_num  = idx;
        return f;
    endfunction

    assign idx_nxt = idx_q + NUM_ONE;
    assign len_ok  = (pkt_num_flits >= NUM_MIN) && (pkt_num_flits <= NUM_MAX);

    always_comb begin
        state_d      = state_q;
        flits_d      = flits_q;
        num_d        = num_q;
        idx_d        = idx_q;
        id_ctr_d     = id_ctr_q;
        flit_out_d   = flit_out_q;
        flit_valid_d = flit_valid_q;
        tx_done_d    = 1'b0;
        tx_done_id_d = tx_done_id_q;
        err_len_d    = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                if (pkt_valid && pkt_ready_q) begin
                    if (len_ok) begin
                        flits_d      = pkt_flits;
                        num_d        = pkt_num_flits;
                        idx_d        = '0;
                        flit_out_d   = stamp(pkt_flits[0], '0, pkt_num_flits, id_ctr_q);
                        flit_valid_d = 1'b1;
                        state_d      = STATE_SEND;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            STATE_SEND: begin
                // The next flit is prepared here so flit_out stays a plain register.
                if (flit_valid_q && flit_ready) begin
                    if (idx_q == num_q - NUM_ONE) begin
                        tx_done_d    = 1'b1;
                        tx_done_id_d = id_ctr_q;
                        id_ctr_d     = id_ctr_q + 1'b1;
                        flit_valid_d = 1'b0;
                        state_d      = STATE_IDLE;
                    end else begin
                        idx_d      = idx_nxt;
                        flit_out_d = stamp(flits_q[idx_nxt[IDX_W-1:0]], idx_nxt, num_q, id_ctr_q);
                    end
                end
            end
            default: state_d = STATE_IDLE;
        endcase

        pkt_ready_d = (state_d == STATE_IDLE);
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= STATE_IDLE;
            flits_q      <= '0;
            num_q        <= '0;
            idx_q        <= '0;
            id_ctr_q     <= '0;
            flit_out_q   <= '0;
            flit_valid_q <= 1'b0;
            pkt_ready_q  <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_done_id_q <= '0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flits_q      <= flits_d;
            num_q        <= num_d;
            idx_q        <= idx_d;
            id_ctr_q     <= id_ctr_d;
            flit_out_q   <= flit_out_d;
            flit_valid_q <= flit_valid_d;
            pkt_ready_q  <= pkt_ready_d;
            tx_done_q    <= tx_done_d;
            tx_done_id_q <= tx_done_id_d;
            err_len_q    <= err_len_d;
        end
    end

    assign pkt_ready  = pkt_ready_q;
    assign flit_out   = flit_out_q;
    assign flit_valid = flit_valid_q;
    assign tx_done    = tx_done_q;
    assign tx_done_id = tx_done_id_q;
    assign err_len    = err_len_q;

endmodule

// File: tb/tb_packet_serializer.sv
// Directed bench for packet_serializer: flit ordering/stamping, stalls, illegal lengths,
// id wrap, reset mid-packet and a stalled loopback receiver.
module tb_packet_serializer;

    logic                     nocclk = 1'b0;
    logic                     rst_n;
    types::flit_t [7:0]       pkt_flits;
    logic [3:0]               pkt_num_flits;
    logic                     pkt_valid;
    logic                     pkt_ready;
    types::flit_t             flit_out;
    logic                     flit_valid;
    logic                     flit_ready;
    logic                     tx_done;
    logic [7:0]               tx_done_id;
    logic                     err_len;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_hs  = 0;

    packet_serializer #(.MAX_FLITS(8), .PACKET_ID_W(8)) dut (
        .nocclk        (nocclk),
        .rst_n         (rst_n),
        .pkt_flits     (pkt_flits),
        .pkt_num_flits (pkt_num_flits),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .flit_out      (flit_out),
        .flit_valid    (flit_valid),
        .flit_ready    (flit_ready),
        .tx_done       (tx_done),
        .tx_done_id    (tx_done_id),
        .err_len       (err_len)
    );

    always #5 nocclk = ~nocclk;
    always @(posedge nocclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge nocclk);
        #1;
    endtask

    function automatic types::flit_t mk(input int i, input int n, input logic [7:0] pid,
                                        input logic [31:0] data);
        types::flit_t f;
        f.flittype          = (i == 0) ? types::HEAD : ((i == n - 1) ? types::TAIL : types::BODY);
        f.flit_id.packet_id = pid;
        f.flit_id.flit_num  = 4'(i);
        f.payload           = data;
        return f;
    endfunction

    // Offer a packet with junk header fields; payload k = base + k. Returns after the handshake edge.
    task automatic offer(input int n, input logic [31:0] base);
        int wait_cnt;
        for (int k = 0; k < 8; k++) begin
            pkt_flits[k].flittype          = types::HEADTAIL;
            pkt_flits[k].flit_id.packet_id = 8'hEE;
            pkt_flits[k].flit_id.flit_num  = 4'hF;
            pkt_flits[k].payload           = base + 32'(k);
        end
        pkt_num_flits = 4'(n);
        pkt_valid     = 1'b1;
        wait_cnt      = 0;
        while (!pkt_ready && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        if (wait_cnt >= 20) check("offer_timeout", 64'd0, 64'd1);
        tick();
        last_hs   = cyc;
        pkt_valid = 1'b0;
        for (int k = 0; k < 8; k++) pkt_flits[k] = types::flit_t'($urandom);
    endtask

    task automatic recv_packet(input int n, input logic [31:0] base, input logic [7:0] pid,
                               input int stall_idx, input int stall_cycles);
        for (int i = 0; i < n; i++) begin
            if (i == stall_idx) begin
                flit_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    check("hold_valid", 64'(flit_valid), 64'd1);
                    check("hold_flit", 64'(flit_out), 64'(mk(i, n, pid, base + 32'(i))));
                    tick();
                end
            end
            flit_ready = 1'b1;
            check("flit_valid", 64'(flit_valid), 64'd1);
            check("flit_out", 64'(flit_out), 64'(mk(i, n, pid, base + 32'(i))));
            check("no_early_done", 64'(tx_done), 64'd0);
            tick();
        end
        check("tx_done", 64'(tx_done), 64'd1);
        check("tx_done_id", 64'(tx_done_id), 64'(pid));
        check("idle_valid", 64'(flit_valid), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        types::flit_t got_flits [8];
        int           got_cnt;
        int           done_seen;
        logic [31:0]  pat;
        int           prev_hs;

        rst_n         = 1'b0;
        pkt_valid     = 1'b0;
        pkt_num_flits = '0;
        pkt_flits     = '0;
        flit_ready    = 1'b0;
        #2;
        check("rst_pkt_ready", 64'(pkt_ready), 64'd0);
        check("rst_flit_valid", 64'(flit_valid), 64'd0);
        check("rst_flit_out", 64'(flit_out), 64'd0);
        check("rst_tx_done", 64'(tx_done), 64'd0);
        check("rst_tx_done_id", 64'(tx_done_id), 64'd0);
        check("rst_err_len", 64'(err_len), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 64'(pkt_ready), 64'd1);

        // Illegal lengths: dropped with one err_len pulse each, no flits, id unaffected.
        offer(1, 32'h100);
        check("len1_err", 64'(err_len), 64'd1);
        check("len1_valid", 64'(flit_valid), 64'd0);
        check("len1_ready", 64'(pkt_ready), 64'd1);
        tick();
        check("len1_err_pulse", 64'(err_len), 64'd0);
        offer(9, 32'h200);
        check("len9_err", 64'(err_len), 64'd1);
        check("len9_valid", 64'(flit_valid), 64'd0);
        check("len9_done", 64'(tx_done), 64'd0);
        tick();
        check("len9_err_pulse", 64'(err_len), 64'd0);
        check("len9_valid2", 64'(flit_valid), 64'd0);

        // 3-flit packet, continuous ready, id 0.
        flit_ready = 1'b1;
        offer(3, 32'hA000);
        recv_packet(3, 32'hA000, 8'd0, -1, 0);
        check("done_err_excl", 64'(err_len), 64'd0);
        check("done_ready", 64'(pkt_ready), 64'd1);
        tick();
        check("done_pulse", 64'(tx_done), 64'd0);

        // 4-flit packet with a 5-cycle stall at idx 1, id 1.
        offer(4, 32'hB000);
        recv_packet(4, 32'hB000, 8'd1, 1, 5);

        // 257 back-to-back two-flit packets: ids wrap, 3 cycles per packet.
        do_reset();
        flit_ready = 1'b1;
        prev_hs    = 0;
        for (int p = 0; p < 257; p++) begin
            offer(2, 32'(p) << 8);
            if (p > 0) check("b2b_period", 64'(last_hs - prev_hs), 64'd3);
            prev_hs = last_hs;
            recv_packet(2, 32'(p) << 8, 8'(p), -1, 0);
        end

        // Reset while showing idx 2 of an 8-flit packet.
        tick();
        offer(8, 32'hC000);
        flit_ready = 1'b1;
        tick();
        tick();
        check("mid_flit_num", 64'(flit_out.flit_id.flit_num), 64'd2);
        check("mid_packet_id", 64'(flit_out.flit_id.packet_id), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(flit_valid), 64'd0);
        check("mid_rst_ready", 64'(pkt_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("after_rst_ready", 64'(pkt_ready), 64'd1);
        check("after_rst_valid", 64'(flit_valid), 64'd0);
        check("after_rst_done", 64'(tx_done), 64'd0);
        offer(2, 32'hD000);
        recv_packet(2, 32'hD000, 8'd0, -1, 0);

        // Stalled receiver collecting a 6-flit packet (id 1).
        pat       = 32'b1011_0010_1101_0001_1001_1100_0101_0110;
        got_cnt   = 0;
        done_seen = 0;
        flit_ready = 1'b0;
        offer(6, 32'hE000);
        for (int c = 0; c < 60 && done_seen == 0; c++) begin
            flit_ready = pat[c % 32];
            if (flit_valid && flit_ready && got_cnt < 8) begin
                got_flits[got_cnt] = flit_out;
                got_cnt++;
            end
            tick();
            if (tx_done) done_seen = 1;
        end
        check("loop_done", 64'(done_seen), 64'd1);
        check("loop_done_id", 64'(tx_done_id), 64'd1);
        check("loop_count", 64'(got_cnt), 64'd6);
        for (int k = 0; k < 6; k++)
            check("loop_flit", 64'(got_flits[k]), 64'(mk(k, 6, 8'd1, 32'hE000 + 32'(k))));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
